gain_ramp: RTL and testbench
============================

# gain_ramp

Per-channel gain slew generator that sits directly upstream of the fractional gain multiplier and drives its 8-bit GAIN input. It accepts a target gain over a valid/ready handshake and walks the applied gain toward it in ±1 LSB steps, paced by the audio sample strobe. This prevents zipper noise on fader moves and provides a click-free soft mute.

## Interface
- STEP_DIV, 4: sample strobes per 1-LSB gain step; legal range 1..255.
- ZC_TIMEOUT, 64: sample strobes a due step may wait for a zero crossing before it is forced; used only with GAIN_RAMP_ZC_EN; legal range 1..255.
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- SAMPLE_EN  in  1  one-cycle strobe, one per audio sample.
- IN  in  16  current two's-complement sample; qualified by SAMPLE_EN; used only with GAIN_RAMP_ZC_EN.
- TGT  in  8  requested target gain.
- TGT_VALID  in  1  TGT is valid; must hold TGT stable until accepted.
- TGT_READY  out  1  block can accept a target.
- MUTE  in  1  level; while high the effective target is 0.
- GAIN  out  8  applied gain, registered; feeds the multiplier.
- BUSY  out  1  ramp in progress.
- AT_TGT  out  1  GAIN equals the effective target.

## Operation
- Registers:
  - tgt_r: 8-bit stored target.
  - gain_r: drives GAIN.
  - state: IDLE or RAMP.
  - div_cnt: 8-bit strobe divider.
  - step_due and zc_cnt, zc build only.
- Effective target: eff = MUTE ? 0 : tgt_r.
- Handshake:
  - TGT_READY = (state == IDLE), combinational from the state register.
  - Acceptance happens on any edge with TGT_VALID && TGT_READY; tgt_r <= TGT at that edge.
- IDLE:
  - If gain_r != eff, go to RAMP next edge and clear div_cnt to 0.
  - An accepted TGT that differs from gain_r with MUTE low enters RAMP on the accepting edge.
- RAMP, on each SAMPLE_EN:
  - If div_cnt == STEP_DIV-1: div_cnt <= 0 and a step is due.
  - Otherwise div_cnt increments.
- Step: gain_r moves 1 toward eff. If the new value equals eff, state <= IDLE on the same edge.
- eff changes mid-ramp (MUTE toggle): direction is re-evaluated at every step. If gain_r == eff without a step, go to IDLE next edge.
- Arithmetic: gain_r stays within 0..255 by construction (always moves toward an in-range eff). No wrap is possible.
- A target accepted while MUTE is high is stored but no ramp starts; releasing MUTE ramps up to it.
- Outputs:
  - BUSY = (state == RAMP).
  - AT_TGT = (gain_r == eff), combinational.

## Timing
- Reset values:
  - GAIN = 0, tgt_r = 0, state = IDLE, div_cnt = 0.
  - BUSY = 0, TGT_READY = 1, AT_TGT = 1 (with MUTE low or high).
- RST asserted mid-ramp: all registers return to reset values on the next edge. The in-flight ramp and the stored target are discarded.
- Latency:
  - Accept to RAMP: 0 cycles (same edge).
  - First step: on the STEP_DIV-th SAMPLE_EN after entering RAMP.
- Full-scale ramp 0→255 takes 255×STEP_DIV sample strobes.
- TGT_VALID presented during RAMP stalls (READY low) until the edge after the ramp completes.
- SAMPLE_EN coinciding with a MUTE change: the step uses the eff value sampled that cycle.

## Configuration
- GAIN_RAMP_ZC_EN defined:
  - A due step sets step_due instead of stepping.
  - A pending step executes on the first SAMPLE_EN where IN == 0 or sign(IN) != sign of the previous strobed sample.
  - If no such sample arrives, the step is forced on the ZC_TIMEOUT-th strobe after becoming due.
  - div_cnt holds while step_due is set.
  - Reset clears step_due, zc_cnt and the previous-sign register (previous sign = 0, positive).
- GAIN_RAMP_ZC_EN undefined: a due step executes immediately; IN is ignored and ZC_TIMEOUT is unused.

## Structure
- Shared package/header:
  - State encoding constants (IDLE = 0, RAMP = 1).
  - GAIN_W = 8, SAMPLE_W = 16.
  - Default STEP_DIV and ZC_TIMEOUT values, shared with the mixer top.
- One natural sub-module: zc_detect. It takes the sample, SAMPLE_EN, CLK and RST, holds the previous-sign register, and outputs a one-cycle zero-cross pulse. It is instantiated only under GAIN_RAMP_ZC_EN.

## Test plan
- Reset: RST high 2 cycles, MUTE low -> GAIN=0, BUSY=0, AT_TGT=1, TGT_READY=1 on the first cycle after release.
- Ramp up: STEP_DIV=4, SAMPLE_EN every 4 clocks, accept TGT=8 -> GAIN increments on every 4th strobe and reaches 8 on strobe 32. BUSY falls and TGT_READY rises on that same edge.
- Stall: TGT_VALID with TGT=3 held during the above ramp -> not accepted until GAIN=8 and IDLE. It is then accepted and the block ramps down to 3 in 20 strobes.
- Mute: at GAIN=8, assert MUTE -> ramps to 0 in 32 strobes with AT_TGT=1 at 0. Deassert MUTE -> ramps back to 8 in 32 strobes.
- Reset mid-ramp: RST at GAIN=5 while ramping to 8 -> GAIN=0, BUSY=0, tgt_r=0 on the next edge, and no further steps occur.
- Zero-cross (macro on, ZC_TIMEOUT=64): step due with IN held at +1000 -> GAIN held. IN=-5 on a strobe -> step on that edge. IN then held constant -> next due step is forced on its 64th strobe after becoming due.

Source files
------------

// File: rtl/gain_ramp_pkg.sv
// Shared definitions for the gain slew generator and the mixer top that hosts it.
// Holds the FSM encoding, bus widths, default pacing constants and the step helper.
// No logic lives here; everything is constant or pure function.
package gain_ramp_pkg;

   localparam int GAIN_W   = 8;
   localparam int SAMPLE_W = 16;

   // Defaults shared with the mixer top so every channel slews at the same rate.
   localparam int DEF_STEP_DIV   = 4;
   localparam int DEF_ZC_TIMEOUT = 64;

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_t;

   typedef logic [GAIN_W-1:0] gain_t;

   // One LSB toward the goal; never overshoots and never wraps because the goal
   // is itself an in-range gain.
   function automatic gain_t step_toward(input gain_t cur, input gain_t goal);
      gain_t res;
      if (goal > cur) begin
         res = cur + gain_t'(1);
      end else if (goal < cur) begin
         res = cur - gain_t'(1);
      end else begin
         res = cur;
      end
      step_toward = res;
   endfunction

endpackage

// File: rtl/gain_ramp_zc_detect.sv
// Zero-crossing detector: flags a strobed sample that is 0 or flips sign vs the last one.
// Latency: combinational pulse on the qualifying SAMPLE_EN cycle; sign history is registered.
// Backpressure: none, follows the sample strobe. Present only when GAIN_RAMP_ZC_EN is defined.
`ifdef GAIN_RAMP_ZC_EN
module zc_detect
   import gain_ramp_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_en,
   input  logic [SAMPLE_W-1:0] sample,
   output logic                zc
);

   // Sign of the previous strobed sample; 0 means positive, which is also the
   // reset assumption so a first negative sample counts as a crossing.
   logic prev_neg;

   // Track the sign of each strobed sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_neg <= 1'b0;
      end else if (sample_en) begin
         prev_neg <= sample[SAMPLE_W-1];
      end
   end

   // The pulse is combinational so a pending gain step can land on the very
   // sample that crosses, not one sample later.
   assign zc = sample_en &&
               ((sample == '0) || (sample[SAMPLE_W-1] != prev_neg));

endmodule
`endif

// File: rtl/gain_ramp.sv
// Gain slew generator: walks GAIN toward the (mute-aware) target in 1-LSB steps per STEP_DIV strobes.
// Latency: accept->RAMP same edge; first step on the STEP_DIV-th strobe; GAIN is registered.
// Backpressure: tgt_ready low for the whole ramp. Optional GAIN_RAMP_ZC_EN defers steps to zero crossings.
module gain_ramp
   import gain_ramp_pkg::*;
#(
   parameter int STEP_DIV   = DEF_STEP_DIV,
   parameter int ZC_TIMEOUT = DEF_ZC_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_en,
   input  logic [SAMPLE_W-1:0] in,
   input  logic [GAIN_W-1:0]   tgt,
   input  logic                tgt_valid,
   output logic                tgt_ready,
   input  logic                mute,
   output logic [GAIN_W-1:0]   gain,
   output logic                busy,
   output logic                at_tgt
);

   localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

   state_t     state;
   state_t     state_nxt;
   gain_t      gain_r;
   gain_t      gain_nxt;
   gain_t      tgt_r;
   gain_t      eff;
   logic [7:0] div_cnt;
   logic [7:0] div_nxt;
   logic       accept;
   logic       step;

`ifdef GAIN_RAMP_ZC_EN
   localparam logic [7:0] ZC_LAST = 8'(ZC_TIMEOUT - 1);

   logic       step_due;
   logic       due_nxt;
   logic [7:0] zc_cnt;
   logic [7:0] zc_cnt_nxt;
   logic       zc;

   zc_detect u_zc_detect (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .sample    (in),
      .zc        (zc)
   );
`else
   // Without zero-cross pacing the sample value and the timeout play no part.
   logic unused_zc;
   assign unused_zc = ^{in, 8'(ZC_TIMEOUT)};
`endif

   // Mute overrides the stored target without disturbing it.
   assign eff    = mute ? '0 : tgt_r;
   assign accept = tgt_valid && tgt_ready;

   assign tgt_ready = (state == IDLE);
   assign busy      = (state == RAMP);
   assign at_tgt    = (gain_r == eff);
   assign gain      = gain_r;

   // Pacing: decide on which strobe a 1-LSB step fires; idle or settled clears it.
   always_comb begin
      step    = 1'b0;
      div_nxt = div_cnt;
`ifdef GAIN_RAMP_ZC_EN
      due_nxt    = step_due;
      zc_cnt_nxt = zc_cnt;
`endif
      if ((state != RAMP) || (gain_r == eff)) begin
         div_nxt = '0;
`ifdef GAIN_RAMP_ZC_EN
         due_nxt    = 1'b0;
         zc_cnt_nxt = '0;
`endif
      end else if (sample_en) begin
`ifdef GAIN_RAMP_ZC_EN
         // A due step waits for a crossing (or the timeout); the divider
         // freezes meanwhile so the step rate is never compressed.
         if (step_due) begin
            if (zc || (zc_cnt == ZC_LAST)) begin
               step       = 1'b1;
               due_nxt    = 1'b0;
               zc_cnt_nxt = '0;
            end else begin
               zc_cnt_nxt = zc_cnt + 8'd1;
            end
         end else if (div_cnt == DIV_LAST) begin
            div_nxt    = '0;
            due_nxt    = 1'b1;
            zc_cnt_nxt = '0;
         end else begin
            div_nxt = div_cnt + 8'd1;
         end
`else
         if (div_cnt == DIV_LAST) begin
            div_nxt = '0;
            step    = 1'b1;
         end else begin
            div_nxt = div_cnt + 8'd1;
         end
`endif
      end
   end

   // Next state and next gain; direction is re-derived from eff on every step.
   always_comb begin
      state_nxt = state;
      gain_nxt  = gain_r;
      case (state)
         IDLE: begin
            // Either eff already moved away (mute toggle) or a fresh target
            // that differs is being accepted on this edge.
            if ((gain_r != eff) || (accept && !mute && (tgt != gain_r))) begin
               state_nxt = RAMP;
            end
         end
         RAMP: begin
            if (gain_r == eff) begin
               // eff came to meet us (mute change) without a step.
               state_nxt = IDLE;
            end else if (step) begin
               gain_nxt = step_toward(gain_r, eff);
               if (gain_nxt == eff) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath registers: applied gain, stored target and pacing counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         gain_r  <= '0;
         tgt_r   <= '0;
         div_cnt <= '0;
      end else begin
         gain_r  <= gain_nxt;
         div_cnt <= div_nxt;
         if (accept) begin
            tgt_r <= tgt;
         end
      end
   end

`ifdef GAIN_RAMP_ZC_EN
   // Zero-cross wait state: pending step flag and strobes waited so far.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_due <= 1'b0;
         zc_cnt   <= '0;
      end else begin
         step_due <= due_nxt;
         zc_cnt   <= zc_cnt_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_gain_ramp.sv
// Directed bench for gain_ramp: reset, ramp up/down, stalled target, mute, reset mid-ramp.
// Zero-cross pacing cases run only when GAIN_RAMP_ZC_EN is defined.
module tb_gain_ramp;

   localparam int STEP_DIV   = 4;
   localparam int ZC_TIMEOUT = 64;
`ifdef GAIN_RAMP_ZC_EN
   // IN idles at 0, which counts as a crossing, so each due step lands one strobe later.
   localparam int PER = STEP_DIV + 1;
`else
   localparam int PER = STEP_DIV;
`endif

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        sample_en = 1'b0;
   logic [15:0] in_s      = '0;
   logic [7:0]  tgt       = '0;
   logic        tgt_valid = 1'b0;
   logic        mute      = 1'b0;
   logic        tgt_ready;
   logic [7:0]  gain;
   logic        busy;
   logic        at_tgt;

   int n_tests = 0;
   int n_fail  = 0;

   gain_ramp #(
      .STEP_DIV   (STEP_DIV),
      .ZC_TIMEOUT (ZC_TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .in        (in_s),
      .tgt       (tgt),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .mute      (mute),
      .gain      (gain),
      .busy      (busy),
      .at_tgt    (at_tgt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // One sample strobe every 4 clocks; returns at the negedge after the strobed edge.
   task automatic strobe();
      repeat (3) @(negedge clk);
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
   endtask

   // Strobe through 'steps' gain steps, checking the hand-derived gain after each strobe.
   task automatic ramp(input string tag, input int start, input int dir,
                       input int steps, input bit done);
      int n;
      n = steps * PER;
      for (int k = 1; k <= n; k++) begin
         strobe();
         chk({tag, " gain"}, int'(gain), start + dir * (k / PER));
         if ((k < n) || !done) chk({tag, " busy"}, int'(busy), 1);
      end
      if (done) begin
         chk({tag, " end busy"}, int'(busy), 0);
         chk({tag, " end ready"}, int'(tgt_ready), 1);
         chk({tag, " end at_tgt"}, int'(at_tgt), 1);
      end
   endtask

   initial begin
      // Reset: two cycles high, then look on the first cycle after release.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset gain", int'(gain), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset at_tgt", int'(at_tgt), 1);
      chk("reset ready", int'(tgt_ready), 1);
      mute = 1'b1;
      #1 chk("reset at_tgt muted", int'(at_tgt), 1);
      mute = 1'b0;

      // Ramp 0 -> 8 with a second target (3) held behind it.
      tgt = 8'd8;
      tgt_valid = 1'b1;
      #1 chk("accept ready", int'(tgt_ready), 1);
      @(negedge clk);
      chk("accept busy", int'(busy), 1);
      chk("accept ready low", int'(tgt_ready), 0);
      tgt = 8'd3;
      ramp("up", 0, 1, 8, 1'b1);

      // The stalled target is taken on the edge after the ramp settles.
      @(negedge clk);
      chk("stall accept busy", int'(busy), 1);
      chk("stall accept ready", int'(tgt_ready), 0);
      tgt_valid = 1'b0;
      ramp("down", 8, -1, 5, 1'b1);

      // Back up to 8, then mute down to 0 and release back up.
      tgt = 8'd8;
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      chk("up2 busy", int'(busy), 1);
      ramp("up2", 3, 1, 5, 1'b1);
      mute = 1'b1;
      #1 chk("mute at_tgt", int'(at_tgt), 0);
      @(negedge clk);
      chk("mute busy", int'(busy), 1);
      ramp("mute", 8, -1, 8, 1'b1);
      mute = 1'b0;
      #1 chk("unmute at_tgt", int'(at_tgt), 0);
      @(negedge clk);
      ramp("unmute", 0, 1, 8, 1'b1);

      // Reset, then store a target while muted: no ramp until mute releases.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mute = 1'b1;
      tgt = 8'd8;
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("muted store busy", int'(busy), 0);
      chk("muted store gain", int'(gain), 0);
      chk("muted store at_tgt", int'(at_tgt), 1);
      mute = 1'b0;
      @(negedge clk);
      chk("release busy", int'(busy), 1);
      ramp("pre-rst", 0, 1, 5, 1'b0);

      // Reset at GAIN=5 mid-ramp discards ramp and stored target.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst gain", int'(gain), 0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst ready", int'(tgt_ready), 1);
      chk("midrst at_tgt", int'(at_tgt), 1);
      for (int k = 0; k < 3 * PER; k++) begin
         strobe();
         chk("post-rst gain", int'(gain), 0);
         chk("post-rst busy", int'(busy), 0);
      end

`ifdef GAIN_RAMP_ZC_EN
      // Due step held while IN stays positive.
      in_s = 16'd1000;
      tgt = 8'd2;
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      chk("zc busy", int'(busy), 1);
      for (int k = 0; k < STEP_DIV + 10; k++) begin
         strobe();
         chk("zc hold gain", int'(gain), 0);
      end
      // Sign flip releases the step on that very strobe.
      in_s = 16'hFFFB;
      strobe();
      chk("zc cross gain", int'(gain), 1);
      // Constant IN: next step becomes due after STEP_DIV strobes and is
      // forced on the ZC_TIMEOUT-th strobe after that.
      for (int k = 0; k < STEP_DIV + ZC_TIMEOUT - 1; k++) begin
         strobe();
         chk("zc wait gain", int'(gain), 1);
      end
      chk("zc wait busy", int'(busy), 1);
      strobe();
      chk("zc forced gain", int'(gain), 2);
      chk("zc forced busy", int'(busy), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
